prng_dual_lfsr: RTL and testbench
=================================

Name: prng_dual_lfsr

Overview:
Parametrised two-layer pseudo-random generator. An upper and a lower Fibonacci LFSR are combined by XOR into an OUT_W-bit word.
- Successor to the fixed 16/8-bit generators: adds configurable widths and tap polynomials, a seed-load handshake, a warm-up phase, all-zero lockup recovery and a valid/ready output stream.
- Sits in the mixed-system stimulus path and feeds randomised words to downstream consumers.

Parameters:
UP_W, 16, upper LFSR width (>=4)
DN_W, 8, lower LFSR width (>=4)
UP_TAPS, 16'hB400, upper feedback tap mask (x^16+x^14+x^13+x^11)
DN_TAPS, 8'hB8, lower feedback tap mask (x^8+x^6+x^5+x^4)
UP_INIT, 16'h1111, upper reset value and zero-substitute (must be non-zero)
DN_INIT, 8'h11, lower reset value and zero-substitute (must be non-zero)
OUT_W, 8, output width (<= min(UP_W, DN_W))
WARMUP, 16, free-running advances after reset or reseed before output is valid (0 allowed)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
seed_valid  in  1  seed offer
seed_ready  out  1  seed can be accepted
seed_up  in  UP_W  upper seed
seed_dn  in  DN_W  lower seed
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts out_data
out_data  out  OUT_W  up[OUT_W-1:0] ^ dn[OUT_W-1:0]
lockup  out  1  one-cycle pulse: zero state replaced by INIT

Behaviour:
- Single clock domain. Reset is synchronous and active-low: rst_n is sampled on the clk rising edge.
- While rst_n=0 on an edge, the registers take these values:
  - up=UP_INIT, dn=DN_INIT
  - FSM=WARM, warm_cnt=0
  - lockup=0
- seed_ready and out_valid are gated by rst_n, so both read 0 while rst_n=0.
- LFSR step: next = {s[W-2:0], ^(s & TAPS)}. The up and dn registers always step together.
- FSM states:
  - WARM: out_valid=0, seed_ready=1. Step every cycle and increment warm_cnt. When warm_cnt reaches WARMUP, go to RUN. With WARMUP=0, go to RUN on the next edge without stepping.
  - RUN: out_valid=1, seed_ready=1. Step only when out_valid && out_ready; otherwise hold out_data stable.
- Seed accept (seed_valid && seed_ready at an edge):
  - up<=seed_up and dn<=seed_dn.
  - Any all-zero seed half is replaced by its INIT value, and lockup pulses for 1 cycle.
  - warm_cnt<=0 and FSM<=WARM.
  - First post-seed valid word appears exactly WARMUP+1 cycles after the accepting edge, equal to the loaded state stepped WARMUP times.
- Seed accept and output transfer on the same edge:
  - The transfer completes with the current word.
  - The seed wins for next state; there is no extra step.
- Seed accept during WARM restarts the warm-up.
- Runtime guard: if up or dn is ever zero in WARM/RUN, it is forced to INIT on the next edge and lockup pulses.
- Reset mid-operation (any state) discards the in-flight word and seed. The outstanding word is not re-presented.
- out_data is combinational from the registers: no latency beyond the registered state.
- seed_ready is independent of out_ready, so the block has no deadlock.
- warm_cnt width is $clog2(WARMUP+1), minimum 1.

Decomposition:
- Package prng_pkg holds:
  - the FSM enum {WARM, RUN}
  - default tap constants for widths 8/16/32
  - a zero-substitute helper function
- Sub-module lfsr_fib (params W, TAPS, INIT):
  - ports clk, rst_n, load, load_val, step, state, zero_fix
  - instantiated twice (upper and lower)
- Top-level prng_dual_lfsr holds the FSM, warm counter, handshake and combiner.

Test Plan:
1. Defaults, WARMUP=0, release reset -> out_valid=1 on 1st edge after release; out_data=8'h00 (8'h11^8'h11). After 1 transfer: up=16'h2223, dn=8'h23, out_data=8'h00.
2. WARMUP=0, seed_up=16'hACE1, seed_dn=8'h5A accepted -> next cycle: out_data=8'hBB, lockup=0. After 1 transfer: up=16'h59C3, dn=8'hB4, out_data=8'h77.
3. Seed seed_up=16'h0000, seed_dn=8'h5A -> lockup=1 for exactly one cycle; up=16'h1111, dn=8'h5A. Never an all-zero state thereafter (10k-cycle check).
4. RUN, out_ready=0 for 20 cycles -> out_data and up/dn unchanged; 1st word after out_ready=1 equals the held value.
5. Defaults (WARMUP=16), seed accepted at edge T -> out_valid=0 through T+16; out_valid=1 at T+17. Reseed at T+8 restarts the count (valid at T+25).
6. Simultaneous seed accept and transfer -> transferred word is the pre-seed value, next word is the seed-derived value. rst_n=0 mid-RUN -> registers back to INIT and out_valid=0 (gated) while rst_n=0. After release: out_valid=1 at release+17 with WARMUP=16, or 1 cycle after release with WARMUP=0.

Source files
------------

// File: rtl/prng_pkg.sv
// Shared types and constants for the dual-LFSR pseudo-random generator.
// Holds the FSM encoding, common tap masks and the zero-substitution helper.
package prng_pkg;

    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } prng_state_e;

    // Fibonacci feedback masks for maximal-length sequences
    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [31:0] TAPS_32 = 32'h8020_0003;

    // Registers of up to 64 bits are supported; callers cast in and out.
    function automatic logic [63:0] zero_sub(input logic [63:0] val, input logic [63:0] init);
        return (val == '0) ? init : val;
    endfunction

endpackage

// File: rtl/lfsr_fib.sv
// Fibonacci LFSR with seed load and all-zero recovery.
// zero_fix flags the cycle in which a zero value is being replaced by INIT.
module lfsr_fib
    import prng_pkg::*;
#(
    parameter int           W    = 8,
    parameter logic [W-1:0] TAPS = TAPS_8,
    parameter logic [W-1:0] INIT = 8'h11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         step,
    output logic [W-1:0] state,
    output logic         zero_fix
);

    logic [W-1:0] next_state;
    logic [W-1:0] seeded;

    assign next_state = {state[W-2:0], ^(state & TAPS)};
    assign seeded     = W'(zero_sub(64'(load_val), 64'(INIT)));
    assign zero_fix   = load ? (load_val == '0) : (state == '0);

    // A zero state would lock the register forever, so it outranks a step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= INIT;
        end else if (load) begin
            state <= seeded;
        end else if (state == '0) begin
            state <= INIT;
        end else if (step) begin
            state <= next_state;
        end
    end

endmodule

// File: rtl/prng_dual_lfsr.sv
// Two-layer PRNG: upper and lower LFSRs XOR-combined into a valid/ready stream,
// with seed handshake, warm-up phase and lockup recovery.
module prng_dual_lfsr
    import prng_pkg::*;
#(
    parameter int              UP_W    = 16,
    parameter int              DN_W    = 8,
    parameter logic [UP_W-1:0] UP_TAPS = TAPS_16,
    parameter logic [DN_W-1:0] DN_TAPS = TAPS_8,
    parameter logic [UP_W-1:0] UP_INIT = 16'h1111,
    parameter logic [DN_W-1:0] DN_INIT = 8'h11,
    parameter int              OUT_W   = 8,
    parameter int              WARMUP  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_valid,
    output logic             seed_ready,
    input  logic [UP_W-1:0]  seed_up,
    input  logic [DN_W-1:0]  seed_dn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             lockup
);

    localparam int               CNT_W     = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP);

    prng_state_e      state, state_nxt;
    logic [CNT_W-1:0] warm_cnt, cnt_nxt;
    logic             step, seed_acc, xfer;
    logic [UP_W-1:0]  up_state;
    logic [DN_W-1:0]  dn_state;
    logic             zf_up, zf_dn;
    logic             unused_hi;

    assign seed_ready = rst_n;
    assign out_valid  = rst_n && (state == RUN);
    assign seed_acc   = seed_valid && seed_ready;
    assign xfer       = out_valid && out_ready;
    assign out_data   = up_state[OUT_W-1:0] ^ dn_state[OUT_W-1:0];
    // Bits above OUT_W only feed the feedback networks.
    assign unused_hi  = ^{up_state, dn_state};

    // A seed always wins over a step; a simultaneous transfer still takes the current word.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = warm_cnt;
        step      = 1'b0;
        if (seed_acc) begin
            state_nxt = WARM;
            cnt_nxt   = '0;
        end else begin
            case (state)
                WARM: begin
                    if (warm_cnt == WARM_LAST) begin
                        state_nxt = RUN;
                    end else begin
                        step    = 1'b1;
                        cnt_nxt = warm_cnt + CNT_W'(1);
                    end
                end
                RUN:     step = xfer;
                default: state_nxt = WARM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= WARM;
            warm_cnt <= '0;
            lockup   <= 1'b0;
        end else begin
            state    <= state_nxt;
            warm_cnt <= cnt_nxt;
            lockup   <= zf_up || zf_dn;
        end
    end

    lfsr_fib #(.W(UP_W), .TAPS(UP_TAPS), .INIT(UP_INIT)) u_up (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (seed_acc),
        .load_val (seed_up),
        .step     (step),
        .state    (up_state),
        .zero_fix (zf_up)
    );

    lfsr_fib #(.W(DN_W), .TAPS(DN_TAPS), .INIT(DN_INIT)) u_dn (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (seed_acc),
        .load_val (seed_dn),
        .step     (step),
        .state    (dn_state),
        .zero_fix (zf_dn)
    );

endmodule

// File: tb/tb_prng_dual_lfsr.sv
// Scoreboard bench for prng_dual_lfsr: a WARMUP=0 instance checked word by word
// against a reference model, and a default WARMUP=16 instance for warm-up timing.
module tb_prng_dual_lfsr;

    logic        clk, rst_n;
    logic        a_seed_valid, a_seed_ready, a_out_valid, a_out_ready, a_lockup;
    logic [15:0] a_seed_up;
    logic [7:0]  a_seed_dn, a_out_data;
    logic        b_seed_valid, b_seed_ready, b_out_valid, b_out_ready, b_lockup;
    logic [15:0] b_seed_up;
    logic [7:0]  b_seed_dn, b_out_data;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  sbq[$];
    logic [7:0]  sb_word;
    logic [15:0] mu;
    logic [7:0]  md;
    logic        mv, mlock;

    prng_dual_lfsr #(.WARMUP(0)) a_dut (
        .clk(clk), .rst_n(rst_n),
        .seed_valid(a_seed_valid), .seed_ready(a_seed_ready),
        .seed_up(a_seed_up), .seed_dn(a_seed_dn),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .lockup(a_lockup)
    );

    prng_dual_lfsr b_dut (
        .clk(clk), .rst_n(rst_n),
        .seed_valid(b_seed_valid), .seed_ready(b_seed_ready),
        .seed_up(b_seed_up), .seed_dn(b_seed_dn),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .lockup(b_lockup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Polynomials written out as explicit tap bits.
    function automatic logic [15:0] nxt16(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [7:0] nxt8(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One cycle of stimulus on instance A, called just after a rising edge.
    task automatic cyc(input logic sv, input logic [15:0] su, input logic [7:0] sd, input logic rdy);
        a_seed_valid = sv;
        a_seed_up    = su;
        a_seed_dn    = sd;
        a_out_ready  = rdy;
        if (rst_n && mv && rdy) sbq.push_back(mu[7:0] ^ md);
        @(negedge clk);
        chk("valid",  32'(a_out_valid),  32'(mv && rst_n));
        chk("lockup", 32'(a_lockup),     32'(mlock));
        chk("sready", 32'(a_seed_ready), 32'(rst_n));
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mu = 16'h1111; md = 8'h11; mv = 1'b0; mlock = 1'b0;
        end else if (sv) begin
            mlock = (su == 16'h0) || (sd == 8'h0);
            mu    = (su == 16'h0) ? 16'h1111 : su;
            md    = (sd == 8'h0)  ? 8'h11    : sd;
            mv    = 1'b0;
        end else begin
            mlock = 1'b0;
            if (!mv) mv = 1'b1;
            else if (rdy) begin
                mu = nxt16(mu);
                md = nxt8(md);
            end
        end
        a_seed_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && a_out_valid && a_out_ready) begin
            chk("sb_avail", 32'(sbq.size() > 0), 32'd1);
            if (sbq.size() > 0) begin
                sb_word = sbq.pop_front();
                chk("sb_word", 32'(a_out_data), 32'(sb_word));
            end
        end
    end

    // Seed instance B, then return the edge count until its first valid word.
    task automatic b_seed_and_wait(input logic [15:0] su, input logic [7:0] sd, output int lat);
        b_seed_valid = 1'b1;
        b_seed_up    = su;
        b_seed_dn    = sd;
        @(posedge clk);
        #1;
        b_seed_valid = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (b_out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] eu, hu;
        logic [7:0]  ed, held;
        int          zeros, lat, fa, fb;

        rst_n = 1'b0;
        a_seed_valid = 1'b0; a_seed_up = '0; a_seed_dn = '0; a_out_ready = 1'b0;
        b_seed_valid = 1'b0; b_seed_up = '0; b_seed_dn = '0; b_out_ready = 1'b0;
        mu = 16'h1111; md = 8'h11; mv = 1'b0; mlock = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",  32'(a_out_valid),     32'd0);
        chk("rst_sready", 32'(a_seed_ready),    32'd0);
        chk("rst_lockup", 32'(a_lockup),        32'd0);
        chk("rst_up",     32'(a_dut.up_state),  32'h1111);
        chk("rst_dn",     32'(a_dut.dn_state),  32'h11);
        chk("rst_bvalid", 32'(b_out_valid),     32'd0);

        // Release with WARMUP=0: valid after one edge, then one transfer
        rst_n = 1'b1;
        cyc(1'b0, 16'h0, 8'h0, 1'b0);
        chk("tp1_valid", 32'(a_out_valid), 32'd1);
        chk("tp1_data",  32'(a_out_data),  32'h00);
        cyc(1'b0, 16'h0, 8'h0, 1'b1);
        chk("tp1_up",    32'(a_dut.up_state), 32'h2223);
        chk("tp1_dn",    32'(a_dut.dn_state), 32'h23);
        chk("tp1_data2", 32'(a_out_data),     32'h00);

        // Seed ACE1/5A
        cyc(1'b1, 16'hACE1, 8'h5A, 1'b0);
        chk("tp2_data",   32'(a_out_data), 32'hBB);
        chk("tp2_lockup", 32'(a_lockup),   32'd0);
        cyc(1'b0, 16'h0, 8'h0, 1'b0);
        cyc(1'b0, 16'h0, 8'h0, 1'b1);
        chk("tp2_up",   32'(a_dut.up_state), 32'h59C3);
        chk("tp2_dn",   32'(a_dut.dn_state), 32'hB4);
        chk("tp2_data", 32'(a_out_data),     32'h77);

        // All-zero upper seed half
        cyc(1'b1, 16'h0000, 8'h5A, 1'b0);
        chk("tp3_lockup", 32'(a_lockup),        32'd1);
        chk("tp3_up",     32'(a_dut.up_state),  32'h1111);
        chk("tp3_dn",     32'(a_dut.dn_state),  32'h5A);
        cyc(1'b0, 16'h0, 8'h0, 1'b0);
        chk("tp3_pulse",  32'(a_lockup),        32'd0);
        zeros = 0;
        for (int i = 0; i < 10000; i++) begin
            cyc(1'b0, 16'h0, 8'h0, 1'($urandom_range(0, 1)));
            if (a_dut.up_state == 16'h0 || a_dut.dn_state == 8'h0) zeros++;
        end
        chk("tp3_nonzero", 32'(zeros), 32'd0);

        // Backpressure hold
        cyc(1'b0, 16'h0, 8'h0, 1'b1);
        held = a_out_data;
        hu   = a_dut.up_state;
        repeat (20) cyc(1'b0, 16'h0, 8'h0, 1'b0);
        chk("tp4_data", 32'(a_out_data),     32'(held));
        chk("tp4_up",   32'(a_dut.up_state), 32'(hu));
        chk("tp4_word", 32'(mu[7:0] ^ md),   32'(held));
        cyc(1'b0, 16'h0, 8'h0, 1'b1);

        // Seed accept on the same edge as a transfer
        cyc(1'b1, 16'h1234, 8'h56, 1'b1);
        cyc(1'b0, 16'h0, 8'h0, 1'b0);
        chk("tp6_next", 32'(a_out_data), 32'h62);
        cyc(1'b0, 16'h0, 8'h0, 1'b1);
        a_out_ready = 1'b0;

        // WARMUP=16 latency on instance B, then a reseed midway through warm-up
        chk("tp5_sready", 32'(b_seed_ready), 32'd1);
        b_seed_and_wait(16'hBEEF, 8'h42, lat);
        chk("tp5_lat", 32'(lat), 32'd17);
        eu = 16'hBEEF; ed = 8'h42;
        repeat (16) begin eu = nxt16(eu); ed = nxt8(ed); end
        chk("tp5_data",   32'(b_out_data), 32'(eu[7:0] ^ ed));
        chk("tp5_lockup", 32'(b_lockup),   32'd0);
        b_seed_valid = 1'b1; b_seed_up = 16'hBEEF; b_seed_dn = 8'h42;
        @(posedge clk);
        #1;
        b_seed_valid = 1'b0;
        fb = 0;
        for (int n = 1; n <= 7; n++) begin
            @(posedge clk);
            #1;
            if (b_out_valid) fb++;
        end
        chk("tp5_early", 32'(fb), 32'd0);
        b_seed_and_wait(16'h1234, 8'h56, lat);
        chk("tp5_relat", 32'(lat), 32'd17);
        eu = 16'h1234; ed = 8'h56;
        repeat (16) begin eu = nxt16(eu); ed = nxt8(ed); end
        chk("tp5_redata", 32'(b_out_data), 32'(eu[7:0] ^ ed));

        // Reset in the middle of RUN with a word on offer
        rst_n = 1'b0;
        cyc(1'b0, 16'h0, 8'h0, 1'b1);
        chk("rst2_up",     32'(a_dut.up_state), 32'h1111);
        chk("rst2_dn",     32'(a_dut.dn_state), 32'h11);
        chk("rst2_valid",  32'(a_out_valid),    32'd0);
        chk("rst2_bvalid", 32'(b_out_valid),    32'd0);
        a_out_ready = 1'b0;
        rst_n = 1'b1;
        fa = 0; fb = 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            if (fa == 0 && a_out_valid) fa = n;
            if (fb == 0 && b_out_valid) fb = n;
        end
        chk("rel_a_lat", 32'(fa), 32'd1);
        chk("rel_b_lat", 32'(fb), 32'd17);
        mu = 16'h1111; md = 8'h11; mv = 1'b1; mlock = 1'b0;
        cyc(1'b0, 16'h0, 8'h0, 1'b1);
        cyc(1'b0, 16'h0, 8'h0, 1'b1);
        a_out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("sb_drain", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
